// File: rtl/cpu_pkg.sv
// Shared ISA constants, instruction field positions and fetch-stage state
// type used by the fetch/PC unit and the decode path.
package cpu_pkg;

  localparam logic [3:0] OP_ADD       = 4'b0000;
  localparam logic [3:0] OP_SUB       = 4'b0001;
  localparam logic [3:0] OP_AND       = 4'b0010;
  localparam logic [3:0] OP_OR        = 4'b0011;
  localparam logic [3:0] OP_MOV       = 4'b0100;
  localparam logic [3:0] OP_LOADI     = 4'b0101;
  localparam logic [3:0] OP_LWD       = 4'b0110;
  localparam logic [3:0] OP_LWI       = 4'b0111;
  localparam logic [3:0] OP_SWD       = 4'b1000;
  localparam logic [3:0] OP_BRANZ     = 4'b1001;
  localparam logic [3:0] OP_BRAZ      = 4'b1010;
  localparam logic [3:0] OP_BRAUNCOND = 4'b1011;

  // Every opcode at or above this value is unassigned.
  localparam logic [3:0] OP_ILLEGAL_MIN = 4'b1100;

  localparam int OPCODE_MSB = 27;
  localparam int OPCODE_LSB = 24;
  localparam int OFFSET_MSB = 23;
  localparam int OFFSET_LSB = 16;

  typedef enum logic {
    FETCH = 1'b0,
    ISSUE = 1'b1
  } fetch_state_t;

  function automatic logic is_illegal_op(input logic [3:0] op);
    return op >= OP_ILLEGAL_MIN;
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC resolution: sequential PC + 4, or PC + 4 plus the
// sign-extended word offset when a branch is taken.
module next_pc_calc #(
  parameter int PC_WIDTH  = 32,
  parameter int OFF_WIDTH = 8
) (
  input  logic [PC_WIDTH-1:0]  pc,
  input  logic [OFF_WIDTH-1:0] offset,
  input  logic                 braz,
  input  logic                 branz,
  input  logic                 brauncond,
  input  logic                 zero,
  input  logic                 illegal,
  output logic [PC_WIDTH-1:0]  next_pc
);

  logic [PC_WIDTH-1:0] seq;
  logic [PC_WIDTH-1:0] off_ext;
  logic [PC_WIDTH-1:0] tgt;
  logic                taken;

  always_comb begin
    seq     = pc + PC_WIDTH'(4);
    off_ext = {{(PC_WIDTH-OFF_WIDTH){offset[OFF_WIDTH-1]}}, offset};
    tgt     = seq + {off_ext[PC_WIDTH-3:0], 2'b00};
    // zero only matters behind a conditional branch, so an X on it is harmless otherwise
    taken   = ~illegal & (brauncond | (braz & zero) | (branz & ~zero));
    next_pc = taken ? tgt : seq;
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch / program-counter stage: fetches one word per FETCH with
// a busywait handshake, holds it during ISSUE, then resolves the next PC.
module fetch_pc_unit
  import cpu_pkg::*;
#(
  parameter int                  PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter int                  OFF_WIDTH = 8,
  parameter int                  TIMEOUT   = 255
) (
  input  logic                CLK,
  input  logic                RESET,
  output logic [PC_WIDTH-1:0] IMEM_ADDRESS,
  output logic                IMEM_READ,
  input  logic [31:0]         IMEM_READDATA,
  input  logic                IMEM_BUSYWAIT,
  output logic [31:0]         INSTRUCTION,
  output logic                INSTR_VALID,
  output logic [PC_WIDTH-1:0] PC,
  input  logic                STALL,
  input  logic                BRAZ,
  input  logic                BRANZ,
  input  logic                BRAUNCOND,
  input  logic                ZERO,
  output logic                ILLEGAL,
  output logic                TIMEOUT_ERR
);

  localparam int WCW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  fetch_state_t        state;
  fetch_state_t        state_nxt;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_nxt;
  logic [31:0]         instr_q;
  logic [WCW-1:0]      wait_cnt;
  logic [WCW-1:0]      wait_inc;
  logic                illegal_q;
  logic                timeout_q;
  logic                illegal_op;

  // controlUnit outputs are undefined for unassigned opcodes, so decode locally
  assign illegal_op = is_illegal_op(instr_q[OPCODE_MSB:OPCODE_LSB]);

  next_pc_calc #(
    .PC_WIDTH  (PC_WIDTH),
    .OFF_WIDTH (OFF_WIDTH)
  ) u_next_pc (
    .pc        (pc_q),
    .offset    (instr_q[OFFSET_LSB +: OFF_WIDTH]),
    .braz      (BRAZ),
    .branz     (BRANZ),
    .brauncond (BRAUNCOND),
    .zero      (ZERO),
    .illegal   (illegal_op),
    .next_pc   (pc_nxt)
  );

  always_ff @(posedge CLK) begin
    if (RESET) state <= FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   if (!IMEM_BUSYWAIT) state_nxt = ISSUE;
      ISSUE:   if (!STALL)         state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
  end

  always_comb begin
    IMEM_READ   = (state == FETCH) && !RESET;
    INSTR_VALID = (state == ISSUE);
  end

  assign wait_inc = (wait_cnt == WCW'(TIMEOUT)) ? wait_cnt : wait_cnt + WCW'(1);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (!IMEM_BUSYWAIT) begin
            instr_q  <= IMEM_READDATA;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_inc;
            if (wait_inc == WCW'(TIMEOUT)) timeout_q <= 1'b1;
          end
        end
        ISSUE: begin
          if (!STALL) begin
            pc_q <= pc_nxt;
            if (illegal_op) illegal_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign IMEM_ADDRESS = pc_q;
  assign PC           = pc_q;
  assign INSTRUCTION  = instr_q;
  assign ILLEGAL      = illegal_q;
  assign TIMEOUT_ERR  = timeout_q;

endmodule
